// File: rtl/fifo_credit_sender_pkg.sv
// Shared definitions for the credit-based FIFO sender: link width, default
// downstream credit depth and the sender state encodings.
package fifo_credit_sender_pkg;

    localparam int PATH_WIDTH   = 32;
    localparam int LINK_CREDITS = 2;

    typedef enum logic [1:0] {
        SND_IDLE    = 2'b00,
        SND_ACTIVE  = 2'b01,
        SND_BLOCKED = 2'b10
    } snd_state_e;

endpackage

// File: rtl/fifo_credit_sender_credit_counter.sv
// Downstream credit counter: starts full, saturates at CREDITS and raises a
// sticky overflow flag when a credit returns while already full.
module credit_counter #(
    parameter int CREDITS = 2,
    parameter int CW      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          zero,
    output logic          ovf
);

    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [CW:0]   sum;

    // One spare bit so a return on a full counter is visible before saturating.
    always_comb begin
        sum     = {1'b0, count_q} - {{CW{1'b0}}, dec} + {{CW{1'b0}}, inc};
        count_d = sum[CW-1:0];
        ovf_d   = ovf_q;
        if (sum > (CW+1)'(CREDITS)) begin
            count_d = CW'(CREDITS);
            ovf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CW'(CREDITS);
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);
    assign ovf   = ovf_q;

endmodule

// File: rtl/fifo_credit_sender.sv
// Pops the port FIFO onto a credit-flow-controlled switch link.
// Optional SENDER_PARITY_EN adds a registered even-parity output link_parity.
module fifo_credit_sender
    import fifo_credit_sender_pkg::*;
#(
    parameter int WIDTH   = PATH_WIDTH,
    parameter int CREDITS = LINK_CREDITS,
    parameter int CW      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             fifo_deq,
    input  logic [WIDTH-1:0] fifo_d_out,
    input  logic             fifo_valid,
    output logic [WIDTH-1:0] link_data,
    output logic             link_valid,
    input  logic             credit_in,
    output logic             blocked,
`ifdef SENDER_PARITY_EN
    output logic             link_parity,
`endif
    output logic             err
);

    logic [CW-1:0] credits;
    logic          credits_zero;
    logic          sent;
    logic [CW:0]   credits_nxt;
    logic          nxt_zero;

    snd_state_e    state_q, state_d;
    logic [WIDTH-1:0] link_data_q, link_data_d;
    logic          link_valid_q, link_valid_d;
    logic          blocked_q, blocked_d;

    credit_counter #(.CREDITS(CREDITS), .CW(CW)) u_credits (
        .clk   (clk),
        .rst   (rst),
        .dec   (sent),
        .inc   (credit_in),
        .count (credits),
        .zero  (credits_zero),
        .ovf   (err)
    );

    // Pop depends only on registered credits, never on the incoming credit.
    assign fifo_deq    = en & ~credits_zero;
    assign sent        = fifo_deq & fifo_valid;
    assign credits_nxt = {1'b0, credits} - {{CW{1'b0}}, sent} + {{CW{1'b0}}, credit_in};
    assign nxt_zero    = (credits_nxt == '0);

    always_ff @(posedge clk) begin
        if (rst) state_q <= SND_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SND_IDLE:    if (en) state_d = credits_zero ? SND_BLOCKED : SND_ACTIVE;
            SND_ACTIVE:  if (!en) state_d = SND_IDLE;
                         else if (nxt_zero) state_d = SND_BLOCKED;
            SND_BLOCKED: if (!en) state_d = SND_IDLE;
                         else if (!nxt_zero) state_d = SND_ACTIVE;
            default:     state_d = SND_IDLE;
        endcase
    end

    always_comb begin
        link_data_d  = sent ? fifo_d_out : link_data_q;
        link_valid_d = sent;
        blocked_d    = (state_d == SND_BLOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_data_q  <= '0;
            link_valid_q <= 1'b0;
            blocked_q    <= 1'b0;
        end else begin
            link_data_q  <= link_data_d;
            link_valid_q <= link_valid_d;
            blocked_q    <= blocked_d;
        end
    end

    assign link_data  = link_data_q;
    assign link_valid = link_valid_q;
    assign blocked    = blocked_q;

`ifdef SENDER_PARITY_EN
    logic link_parity_q, link_parity_d;

    assign link_parity_d = sent ? ^fifo_d_out : link_parity_q;

    always_ff @(posedge clk) begin
        if (rst) link_parity_q <= 1'b0;
        else     link_parity_q <= link_parity_d;
    end

    assign link_parity = link_parity_q;
`endif

endmodule

// File: doc/fifo_credit_sender.md
Name: fifo_credit_sender

Overview:
Reader end of the switch-port input FIFO. It pops words from a `fifo` instance and drives them onto a DySER switch link that uses credit-based flow control. It tracks the downstream buffer space with a credit counter, so no word is ever sent without a credit. It sits between the port FIFO and the first switch hop.

Parameters:
WIDTH, `PATH_WIDTH, data word width.
CREDITS, 2, downstream buffer depth; this is the initial and maximum credit count.
CW, 2, credit counter width; must hold CREDITS (CW >= clog2(CREDITS+1)).

Ports:
clk  in  1  clock, all state updates on posedge.
rst  in  1  synchronous, active-high reset.
en  in  1  sender enable from config logic.
fifo_deq  out  1  pop request to the FIFO; combinational.
fifo_d_out  in  WIDTH  FIFO head data; valid in the same cycle as fifo_deq.
fifo_valid  in  1  FIFO confirms the pop (same cycle, combinational in the FIFO).
link_data  out  WIDTH  registered link data.
link_valid  out  1  registered; a one-cycle pulse per word sent.
credit_in  in  1  one credit returned by downstream per cycle asserted.
blocked  out  1  registered; high while credits == 0 and en == 1.
err  out  1  sticky credit-overflow flag.

Behaviour:
- Reset values (rst high at posedge):
  - link_data = 0, link_valid = 0, blocked = 0, err = 0.
  - credits = CREDITS, state = IDLE.
- fifo_deq = en & (credits != 0).
  - Purely combinational from registered credits and en; it never depends on credit_in.
  - Popping an empty FIFO is legal and simply yields fifo_valid = 0.
- sent = fifo_deq & fifo_valid.
  - On posedge with sent: link_data <= fifo_d_out, link_valid <= 1.
  - Otherwise: link_valid <= 0 and link_data holds its value.
- Latency and throughput:
  - One cycle from the FIFO pop to link_valid.
  - Sustained rate is 1 word/cycle while credits remain.
- Credit update: credits_next = credits - sent + credit_in, in (CW+1)-bit arithmetic.
  - sent and credit_in in the same cycle leave credits unchanged.
  - If credits == CREDITS and credit_in occurs without sent: credits stays at CREDITS (saturates) and err <= 1.
  - err is sticky until rst.
  - credits never underflows, because sent requires credits != 0.
- States (2-bit encoding):
  - IDLE (00): en = 0. Go to ACTIVE when en = 1 and credits != 0; go to BLOCKED when en = 1 and credits == 0.
  - ACTIVE (01): popping allowed. Go to BLOCKED when credits_next == 0; go to IDLE when en = 0.
  - BLOCKED (10): no pops. Go to ACTIVE when credits_next != 0; go to IDLE when en = 0.
  - blocked output <= (next state == BLOCKED).
  - Credits keep counting in every state, including IDLE.
- en dropping mid-stream:
  - fifo_deq drops in the same cycle, so no word is lost.
  - A word captured at the previous edge still shows link_valid for its one cycle.
- Credit loop timing: credit_in in BLOCKED in cycle N gives fifo_deq = 1 in cycle N+1 and link_valid in cycle N+2.
- Reset mid-stream:
  - Any link_valid pulse is cancelled at the reset edge.
  - credits reloads to CREDITS.
  - FIFO contents are not touched; the FIFO is reset separately.

Optional Feature:
Macro: SENDER_PARITY_EN.
- Defined: adds output port link_parity (1 bit, registered) = ^fifo_d_out, captured together with link_data. Reset value is 0; it holds when no word is sent.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- config.v (shared include) holds:
  - `PATH_WIDTH
  - the state encodings `SND_IDLE / `SND_ACTIVE / `SND_BLOCKED
  - the default credit depth `LINK_CREDITS, used by both the sender and the downstream switch buffer.
- One sub-module: credit_counter (parameters CREDITS, CW).
  - Inputs: clk, rst, dec, inc.
  - Outputs: count, zero, ovf.
  - It implements the saturation and overflow rules above.

Test Plan:
- Reset: with rst high for 1 cycle then en = 1 and the FIFO empty -> link_valid = 0, blocked = 0, err = 0, fifo_deq = 1, no word sent.
- Enqueue 1, 2, 3, 4 into the FIFO, en = 1, no credit_in, CREDITS = 2:
  - link shows 1 and 2 on consecutive cycles.
  - blocked = 1 from the cycle after word 2.
  - words 3 and 4 remain in the FIFO.
- From that blocked state, pulse credit_in for 1 cycle -> word 3 appears 2 cycles later, then blocked = 1 again.
- Streaming with credit_in held high every cycle -> 4 words on 4 consecutive cycles, credits stays at 2, blocked is never set.
- Idle with full credits (2), pulse credit_in -> err = 1 next cycle and stays 1 until rst; credits stays at 2.
- Drop en in the same cycle that word 2 would pop -> fifo_deq = 0, link carries only word 1, state = IDLE; re-enable -> word 2 follows.
